ex_mem_stage: RTL
=================

# ex_mem_stage

EX/MEM pipeline stage register of the 16-bit pipelined processor, sitting directly upstream of `memory_module`. It captures the execute-stage result and control bits, forwards writeback data into store data, and drives the data memory's address, write-data and read/write strobes. It also provides load-use hazard indication to decode, stall and flush handling, address-range checking, and per-entry access counters.

## Interface
- `DATA_W`, 16, data and address width
- `REG_W`, 3, register-index width
- `MEM_DEPTH`, 16, number of valid data-memory words; legal addresses are 0..MEM_DEPTH-1
- `CLOCK` in 1: single clock; all state updates on the rising edge
- `in_rst` in 1: synchronous, active-high reset
- `ex_valid` in 1: EX stage holds a real instruction
- `ex_alu_result` in DATA_W: effective address, or ALU result
- `ex_store_data` in DATA_W: rs2 value read in EX
- `ex_rs2` in REG_W: store-data source register index
- `ex_rd` in REG_W: destination register index
- `ex_mem_read`, `ex_mem_write`, `ex_reg_write` in 1 each: control bits
- `in_stall` in 1: hold the current entry
- `in_flush` in 1: squash the incoming entry
- `wb_reg_write` in 1, `wb_rd` in REG_W, `wb_data` in DATA_W: writeback forwarding path
- `out_mem_addr` out DATA_W: to `memory_module` `in_mem_addr`
- `out_mem_data` out DATA_W: to `memory_module` `in_mem_data`
- `out_cntrl_mem_read`, `out_cntrl_mem_write` out 1: memory strobes
- `out_valid` out 1, `out_alu_result` out DATA_W, `out_rd` out REG_W, `out_reg_write` out 1, `out_mem_to_reg` out 1: to MEM/WB
- `out_load_hazard` out 1: registered entry is a valid load; decode compares against its sources
- `out_fault` out 1: sticky illegal-access flag
- `out_load_count`, `out_store_count` out 16: saturating access counters

## Operation
- Capture condition:
  - With `in_stall`=0, each rising edge loads the EX inputs into the entry.
  - With `in_stall`=1, the entry holds unchanged.
  - `in_flush`=1 overrides `in_stall`: the next valid bit is 0 and all other fields load as usual.
- Store-data forwarding is evaluated at capture only. If `wb_reg_write` and `wb_rd==ex_rs2` and `wb_rd!=0`, the captured store data is `wb_data`; otherwise it is `ex_store_data`.
- Entry legality is evaluated at capture and stored as flag `legal`. An entry is illegal if it is valid and either:
  - both `ex_mem_read` and `ex_mem_write` are set, or
  - it performs a memory access with `ex_alu_result >= MEM_DEPTH`.
- A valid illegal entry sets `out_fault` at capture. `out_fault` stays set until reset.
- `out_mem_addr` equals the registered `alu_result`. `out_mem_data` equals the registered store data.
- `out_cntrl_mem_read` = valid & mem_read & legal.
- `out_cntrl_mem_write` = valid & mem_write & legal & !wr_done.
  - `wr_done` is set on the first edge where the write strobe is high and `in_stall`=1.
  - `wr_done` clears on any capture.
  - Result: one write per entry even under a multi-cycle stall.
- `out_mem_to_reg` = registered mem_read. `out_reg_write` = registered reg_write & valid & legal.
- `out_load_hazard` = valid & mem_read.
- Counters:
  - `out_load_count` increments once per captured-valid legal load.
  - `out_store_count` increments once per captured-valid legal store.
  - Both increment at the capture edge and saturate at 16'hFFFF.

## Timing
- Latency is 1 cycle from the EX inputs to every output.
- Memory strobes are combinational from registered state; `memory_module` writes on the next rising edge.
- On `in_rst`=1 at an edge, every output and internal flag clears to 0: valid, all fields, `legal`, `wr_done`, fault, counters. Reset overrides stall and flush.
- Reset asserted mid-stall drops the held entry with no write.
- On simultaneous `in_stall` and `in_flush`, flush wins: a bubble is inserted and counters do not increment.
- A flushed or invalid entry never raises a strobe, the fault flag, or a counter.

## Test plan
- Reset then store: `ex_alu_result`=4, `ex_store_data`=16'h03F8, mem_write=1 → next cycle `out_mem_addr`=4, `out_mem_data`=16'h03F8, write strobe 1 for exactly one cycle, `out_store_count`=1.
- Forwarding: store with `ex_rs2`=3, `wb_reg_write`=1, `wb_rd`=3, `wb_data`=16'h00AA → `out_mem_data`=16'h00AA. Repeat with `wb_rd`=0 → `ex_store_data` is used.
- Stall: store captured, then `in_stall`=1 for 3 cycles → write strobe high only in the first cycle, address and data held for 4 cycles, `out_store_count`=1.
- Illegal access: load at address 16'h019A with `MEM_DEPTH`=16 → no read strobe, `out_fault`=1 and stays 1 after later legal loads, `out_load_count` unchanged, `out_reg_write`=0.
- Load hazard and flush: valid load to rd=2 → `out_load_hazard`=1, `out_mem_to_reg`=1. Then assert `in_flush` with `in_stall` → `out_valid`=0 and all strobes 0.
- Reset mid-operation: assert `in_rst` during a stalled store → next cycle all outputs 0, counters 0, fault 0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures execute results, forwards writeback data
// into store data, and drives the data-memory strobes with fault and access counting.
module ex_mem_stage #(
  parameter int DATA_W    = 16,
  parameter int REG_W     = 3,
  parameter int MEM_DEPTH = 16
) (
  input  logic              CLOCK,
  input  logic              in_rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_rs2,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic              in_stall,
  input  logic              in_flush,
  input  logic              wb_reg_write,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] out_mem_addr,
  output logic [DATA_W-1:0] out_mem_data,
  output logic              out_cntrl_mem_read,
  output logic              out_cntrl_mem_write,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_reg_write,
  output logic              out_mem_to_reg,
  output logic              out_load_hazard,
  output logic              out_fault,
  output logic [15:0]       out_load_count,
  output logic [15:0]       out_store_count
);

  localparam logic [DATA_W-1:0] DepthLimit = DATA_W'(MEM_DEPTH);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] aluResult_q, aluResult_d;
  logic [DATA_W-1:0] storeData_q, storeData_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              memRead_q, memRead_d;
  logic              memWrite_q, memWrite_d;
  logic              regWrite_q, regWrite_d;
  logic              legal_q, legal_d;
  logic              wrDone_q, wrDone_d;
  logic              fault_q, fault_d;
  logic [15:0]       loadCount_q, loadCount_d;
  logic [15:0]       storeCount_q, storeCount_d;

  logic captureEn;
  logic capValid;
  logic capIllegal;
  logic fwdHit;
  logic wrStrobe;

  // Flush forces a capture even while stalled so the bubble actually lands.
  assign captureEn  = !in_stall || in_flush;
  assign capValid   = ex_valid && !in_flush;
  assign capIllegal = capValid && ((ex_mem_read && ex_mem_write) ||
                      ((ex_mem_read || ex_mem_write) && (ex_alu_result >= DepthLimit)));
  assign fwdHit     = wb_reg_write && (wb_rd == ex_rs2) && (wb_rd != '0);
  assign wrStrobe   = valid_q && memWrite_q && legal_q && !wrDone_q;

  always_comb begin
    valid_d      = valid_q;
    aluResult_d  = aluResult_q;
    storeData_d  = storeData_q;
    rd_d         = rd_q;
    memRead_d    = memRead_q;
    memWrite_d   = memWrite_q;
    regWrite_d   = regWrite_q;
    legal_d      = legal_q;
    wrDone_d     = wrDone_q;
    fault_d      = fault_q;
    loadCount_d  = loadCount_q;
    storeCount_d = storeCount_q;
    if (captureEn) begin
      valid_d     = capValid;
      aluResult_d = ex_alu_result;
      storeData_d = fwdHit ? wb_data : ex_store_data;
      rd_d        = ex_rd;
      memRead_d   = ex_mem_read;
      memWrite_d  = ex_mem_write;
      regWrite_d  = ex_reg_write;
      legal_d     = !capIllegal;
      wrDone_d    = 1'b0;
      fault_d     = fault_q || capIllegal;
      if (capValid && !capIllegal && ex_mem_read && (loadCount_q != 16'hFFFF))
        loadCount_d = loadCount_q + 16'd1;
      if (capValid && !capIllegal && ex_mem_write && (storeCount_q != 16'hFFFF))
        storeCount_d = storeCount_q + 16'd1;
    end else if (wrStrobe) begin
      // Held entry already wrote once; suppress repeats for the rest of the stall.
      wrDone_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (in_rst) begin
      valid_q      <= 1'b0;
      aluResult_q  <= '0;
      storeData_q  <= '0;
      rd_q         <= '0;
      memRead_q    <= 1'b0;
      memWrite_q   <= 1'b0;
      regWrite_q   <= 1'b0;
      legal_q      <= 1'b0;
      wrDone_q     <= 1'b0;
      fault_q      <= 1'b0;
      loadCount_q  <= '0;
      storeCount_q <= '0;
    end else begin
      valid_q      <= valid_d;
      aluResult_q  <= aluResult_d;
      storeData_q  <= storeData_d;
      rd_q         <= rd_d;
      memRead_q    <= memRead_d;
      memWrite_q   <= memWrite_d;
      regWrite_q   <= regWrite_d;
      legal_q      <= legal_d;
      wrDone_q     <= wrDone_d;
      fault_q      <= fault_d;
      loadCount_q  <= loadCount_d;
      storeCount_q <= storeCount_d;
    end
  end

  assign out_mem_addr        = aluResult_q;
  assign out_mem_data        = storeData_q;
  assign out_cntrl_mem_read  = valid_q && memRead_q && legal_q;
  assign out_cntrl_mem_write = wrStrobe;
  assign out_valid           = valid_q;
  assign out_alu_result      = aluResult_q;
  assign out_rd              = rd_q;
  assign out_reg_write       = regWrite_q && valid_q && legal_q;
  assign out_mem_to_reg      = memRead_q;
  assign out_load_hazard     = valid_q && memRead_q;
  assign out_fault           = fault_q;
  assign out_load_count      = loadCount_q;
  assign out_store_count     = storeCount_q;

endmodule
